// File: rtl/rgmii_rx_framer_if.sv
`default_nettype none
// ============================================================================
//  Module      : rgmii_rx_framer_if
//  Description : Byte stream from the RGMII receive framer to the MAC receive
//                path. There is no backpressure, so the stream is
//                valid/last/user only.
//                  m_data  [7:0]  payload byte, held while m_valid is low
//                  m_valid        one-cycle strobe per byte
//                  m_last         final byte of the frame (with m_valid)
//                  m_user         frame error, meaningful on the m_last beat
//                master = framer side, slave = consumer side.
//  Revision    : 1.0  initial release
// ============================================================================
interface rgmii_rx_framer_if;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_last;
    logic       m_user;

    modport master (output m_data, m_valid, m_last, m_user);
    modport slave  (input  m_data, m_valid, m_last, m_user);
endinterface
`default_nettype wire

// File: rtl/rgmii_rx_framer.sv
`default_nettype none
// ============================================================================
//  Module      : rgmii_rx_framer
//  Description : Takes the rise/fall sample pairs from the RGMII DDR input
//                stage. It rebuilds bytes and RX_DV/RX_ER, strips the
//                preamble and SFD, and emits a valid/last/user byte stream.
//                Malformed frames are dropped. Between frames it decodes the
//                in-band link status and reports false carrier.
//  Ports       : clk, rst_n              clock, async active-low reset
//                rxd_rise/rxd_fall       low/high data nibble
//                rx_ctl_rise/rx_ctl_fall RX_DV / RX_DV^RX_ER
//                m_if (master)           output byte stream
//                frame_drop              pulse once per discarded frame
//                false_carrier           pulse on a false-carrier idle byte
//                link_up/link_speed/full_duplex  in-band status
//  Revision    : 1.0  initial release
// ============================================================================
module rgmii_rx_framer #(
    parameter int unsigned MIN_PREAMBLE = 1,
    parameter int unsigned MAX_PREAMBLE = 7
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    input  wire logic [3:0]   rxd_rise,
    input  wire logic [3:0]   rxd_fall,
    input  wire logic         rx_ctl_rise,
    input  wire logic         rx_ctl_fall,
    rgmii_rx_framer_if.master m_if,
    output logic              frame_drop,
    output logic              false_carrier,
    output logic              link_up,
    output logic [1:0]        link_speed,
    output logic              full_duplex
);

    localparam int              c_CNT_W   = $clog2(MAX_PREAMBLE + 2);
    localparam logic [c_CNT_W-1:0] c_MAX_CNT = c_CNT_W'(MAX_PREAMBLE);
    localparam logic [c_CNT_W-1:0] c_MIN_CNT = c_CNT_W'(MIN_PREAMBLE);
    localparam logic [c_CNT_W-1:0] c_ONE     = c_CNT_W'(1);
    localparam logic [7:0]      c_PRE     = 8'h55;
    localparam logic [7:0]      c_SFD     = 8'hD5;
    localparam logic [7:0]      c_FCARR   = 8'h0E;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_PREAMBLE = 2'd1,
        S_PAYLOAD  = 2'd2,
        S_DROP     = 2'd3
    } state_t;

    // Registered decode of the DDR pair
    logic [7:0]         r_byte;
    logic               r_dv;
    logic               r_er;

    state_t             r_state, w_state_next;
    logic [c_CNT_W-1:0] r_cnt, w_cnt_next;
    logic [7:0]         r_hold;
    logic               r_hold_vld;
    logic               r_sticky;
    logic [7:0]         r_data_q;     // last emitted byte, keeps m_data stable
    logic               r_link_up;
    logic [1:0]         r_link_speed;
    logic               r_full_duplex;

    logic               w_load;       // capture decode byte into hold register
    logic               w_frame_end;  // payload ended, clear hold and sticky
    logic               w_emit;
    logic               w_last;
    logic               w_user;
    logic               w_drop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_byte <= 8'h00;
            r_dv   <= 1'b0;
            r_er   <= 1'b0;
        end else begin
            r_byte <= {rxd_fall, rxd_rise};
            r_dv   <= rx_ctl_rise;
            r_er   <= rx_ctl_rise ^ rx_ctl_fall;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_load       = 1'b0;
        w_frame_end  = 1'b0;
        w_emit       = 1'b0;
        w_last       = 1'b0;
        w_user       = 1'b0;
        w_drop       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_dv) begin
                    if (r_byte == c_PRE) begin
                        w_cnt_next   = c_ONE;
                        w_state_next = (c_ONE > c_MAX_CNT) ? S_DROP : S_PREAMBLE;
                    end else if (r_byte == c_SFD && MIN_PREAMBLE == 0) begin
                        w_state_next = S_PAYLOAD;
                    end else begin
                        w_state_next = S_DROP;
                    end
                end
            end
            S_PREAMBLE: begin
                if (!r_dv) begin
                    w_drop       = 1'b1;
                    w_state_next = S_IDLE;
                end else if (r_er) begin
                    w_state_next = S_DROP;
                end else if (r_byte == c_PRE) begin
                    if (r_cnt >= c_MAX_CNT) begin
                        w_state_next = S_DROP;
                    end else begin
                        w_cnt_next = r_cnt + c_ONE;
                    end
                end else if (r_byte == c_SFD && r_cnt >= c_MIN_CNT) begin
                    w_state_next = S_PAYLOAD;
                end else begin
                    w_state_next = S_DROP;
                end
            end
            S_PAYLOAD: begin
                if (r_dv) begin
                    // Held byte goes out only now that a successor exists
                    w_load = 1'b1;
                    w_emit = r_hold_vld;
                end else begin
                    w_frame_end  = 1'b1;
                    w_state_next = S_IDLE;
                    if (r_hold_vld) begin
                        w_emit = 1'b1;
                        w_last = 1'b1;
                        w_user = r_sticky;
                    end else begin
                        w_drop = 1'b1;
                    end
                end
            end
            S_DROP: begin
                if (!r_dv) begin
                    w_drop       = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold     <= 8'h00;
            r_hold_vld <= 1'b0;
            r_sticky   <= 1'b0;
            r_data_q   <= 8'h00;
        end else begin
            if (w_load) begin
                r_hold     <= r_byte;
                r_hold_vld <= 1'b1;
                if (r_er) begin
                    r_sticky <= 1'b1;
                end
            end
            if (w_frame_end) begin
                r_hold_vld <= 1'b0;
                r_sticky   <= 1'b0;
            end
            if (w_emit) begin
                r_data_q <= r_hold;
            end
        end
    end

    // Every state returns to IDLE on dv=0, so a clean idle byte is always
    // in-band status regardless of the current state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_link_up     <= 1'b0;
            r_link_speed  <= 2'b00;
            r_full_duplex <= 1'b0;
        end else if (!r_dv && !r_er) begin
            r_link_up     <= r_byte[0];
            r_link_speed  <= r_byte[2:1];
            r_full_duplex <= r_byte[3];
        end
    end

    assign m_if.m_valid  = w_emit;
    assign m_if.m_last   = w_last;
    assign m_if.m_user   = w_user;
    assign m_if.m_data   = w_emit ? r_hold : r_data_q;
    assign frame_drop    = w_drop;
    assign false_carrier = !r_dv && r_er && (r_byte == c_FCARR);
    assign link_up       = r_link_up;
    assign link_speed    = r_link_speed;
    assign full_duplex   = r_full_duplex;

endmodule
`default_nettype wire

// File: doc/rgmii_rx_framer.md
# rgmii_rx_framer

Consumes the per-clock DDR sample pairs produced by the RGMII receive input stage and turns them into a framed byte stream for the MAC receive path. Reconstructs bytes and RX_DV/RX_ER from rise/fall halves, strips preamble and SFD, and flags malformed frames. Emits a valid/last/user byte stream with no backpressure. Decodes RGMII in-band link status between frames.

## Interface

Parameters:
- `MIN_PREAMBLE`, 1: minimum count of 0x55 bytes required before the SFD.
- `MAX_PREAMBLE`, 7: maximum count of 0x55 bytes tolerated before the SFD.

Ports:
- `clk`  in  1  RX clock, the same domain as the DDR input stage outputs.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `rxd_rise`  in  4  data nibble captured on the rising edge, i.e. the low nibble.
- `rxd_fall`  in  4  data nibble captured on the falling edge, i.e. the high nibble.
- `rx_ctl_rise`  in  1  RX_DV.
- `rx_ctl_fall`  in  1  RX_DV xor RX_ER.
- `m_data`  out  8  payload byte.
- `m_valid`  out  1  `m_data` is valid this cycle.
- `m_last`  out  1  final byte of the frame; qualified by `m_valid`.
- `m_user`  out  1  frame error; meaningful only on the `m_last` beat.
- `frame_drop`  out  1  one-cycle pulse when a frame is discarded with no output.
- `false_carrier`  out  1  one-cycle pulse on a false-carrier indication.
- `link_up`  out  1  in-band link status.
- `link_speed`  out  2  in-band speed: 00 = 10M, 01 = 100M, 10 = 1G.
- `full_duplex`  out  1  in-band duplex.

## Operation

Decode stage (registered, every cycle):
- byte = {rxd_fall, rxd_rise}
- dv = rx_ctl_rise
- er = rx_ctl_rise ^ rx_ctl_fall

FSM, driven by the registered decode:
- IDLE
  - dv=1, byte=0x55 → PREAMBLE, preamble count = 1.
  - dv=1, byte=0xD5 with `MIN_PREAMBLE`=0 → PAYLOAD.
  - dv=1, any other byte → DROP.
- PREAMBLE
  - 0x55 → increment count. If count would exceed `MAX_PREAMBLE` → DROP.
  - 0xD5 with count ≥ `MIN_PREAMBLE` → PAYLOAD; otherwise → DROP.
  - Any other byte, or er=1 → DROP.
  - dv=0 → IDLE and pulse `frame_drop`.
- PAYLOAD
  - Each dv=1 byte is loaded into a one-byte hold register. The previously held byte, if any, is emitted with `m_valid`=1, `m_last`=0.
  - er=1 with dv=1 sets a sticky error flag; the byte is still forwarded.
  - dv=0: the held byte is emitted with `m_last`=1 and `m_user` = sticky flag. Sticky flag clears, → IDLE.
  - dv=0 with no held byte (SFD immediately followed by end) → emit nothing, pulse `frame_drop`, → IDLE.
- DROP
  - Nothing is emitted. On dv=0 → pulse `frame_drop`, → IDLE.
  - `frame_drop` pulses exactly once per dropped frame.

Idle decode (only when dv=0, er=0, in any state transitioning to or remaining in IDLE):
- `link_up` = byte[0]
- `link_speed` = byte[2:1]
- `full_duplex` = byte[3]
- These outputs hold between frames and are not updated while dv=1.

False carrier: dv=0, er=1, byte=0x0E → `false_carrier` pulse. Link status is not updated. Any other dv=0/er=1 byte (carrier extend) is ignored.

Back-to-back frames with a single dv=0 cycle between them are accepted. That dv=0 cycle both terminates the previous frame and returns the FSM to IDLE.

## Timing

- Latency: a payload byte at the inputs in cycle t is on `m_data` with `m_valid`=1 in cycle t+2 at the earliest. The byte is emitted only once its successor or the dv=0 end marker is known.
- Last byte: the input dv falls in cycle t+1; `m_last` is asserted in cycle t+2.
- `m_valid` is a single-cycle strobe per byte; there is no ready signal.
- `m_data` is held when `m_valid`=0.
- Reset values: all outputs 0, including `m_data`; FSM = IDLE; hold register empty; sticky flag = 0; link status = 0.
- Reset asserted mid-frame: any partial frame is abandoned with no `m_last`. After release, the FSM waits in IDLE and requires a fresh preamble.
- If dv is still high on release, those bytes fall into DROP unless they are 0x55/0xD5.

## Test plan

- Good frame: dv=1 with 7×0x55, 0xD5, then 0x01..0x40 (64 bytes), then dv=0.
  - Required: 64 `m_valid` beats carrying 0x01..0x40, `m_last` only on 0x40, `m_user`=0.
  - First beat appears 2 cycles after 0x01 is presented.
- RX_ER on payload byte 10 (`rx_ctl_fall`=0 with `rx_ctl_rise`=1): all 64 bytes still emitted; `m_user`=1 on the `m_last` beat only.
- Bad preamble: 0x55, 0x55, 0x5D, then 20 bytes, then dv=0. Required: no `m_valid`, exactly one `frame_drop` pulse on the dv=0 cycle.
- Preamble overrun: 8×0x55 then 0xD5 with `MAX_PREAMBLE`=7 → DROP, no output, one `frame_drop`. Also cover SFD followed directly by dv=0 → one `frame_drop`, no output.
- In-band status and false carrier:
  - Idle byte 0x0D with dv=0, er=0 → `link_up`=1, `link_speed`=10, `full_duplex`=1.
  - Idle byte 0x0E with er=1 → one `false_carrier` pulse, link status unchanged.
- Reset mid-frame: `rst_n` low after payload byte 5 → all outputs 0 within the same cycle, no `m_last`. A subsequent good 2-byte frame is received intact.
